bg_ram_writer: RTL



---
 rtl/bg_ram_writer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bg_ram_writer.sv
// Write-side client for the 1-bit background RAM. Converts (x, y, colour) plot
// requests into single RAM writes and offers a bulk fill that sweeps every
// location with a constant bit. All outputs are registered; in_ready is the
// only combinational output.
module bg_ram_writer #(
  parameter int unsigned H_PIXELS = 160,
  parameter int unsigned V_PIXELS = 120,
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned COLOR_W  = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_x,
  input  logic [7:0]         in_y,
  input  logic [COLOR_W-1:0] in_color,
  input  logic               in_plot,
  output logic               in_ready,
  input  logic               fill_start,
  input  logic               fill_value,
  output logic               busy,
  output logic               fill_done,
  output logic [ADDR_W-1:0]  ram_address,
  output logic               ram_data,
  output logic               ram_wren,
  output logic [7:0]         drop_count
);

  localparam logic [ADDR_W-1:0] FillLast = ADDR_W'(H_PIXELS * V_PIXELS - 1);

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                data_q, data_d;
  logic                wren_q, wren_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [7:0]          drop_q, drop_d;
  logic                in_range;
  logic [ADDR_W-1:0]   plot_addr;

  // Fill has priority over plot: a fill_start cycle never accepts a plot.
  assign in_ready = (state_q == StIdle) && !fill_start;

  assign in_range  = (32'(in_x) < H_PIXELS) && (32'(in_y) < V_PIXELS);
  // Linear address computed at 32 bits, then truncated to the RAM width.
  assign plot_addr = ADDR_W'(32'(in_y) * H_PIXELS + 32'(in_x));

  // Next-state and registered-output logic for the plot/fill FSM.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    drop_d  = drop_q;
    case (state_q)
      StIdle: begin
        if (fill_start) begin
          // ram_data holds the latched fill bit for the whole sweep.
          state_d = StFill;
          addr_d  = '0;
          data_d  = fill_value;
          wren_d  = 1'b1;
          busy_d  = 1'b1;
        end else if (in_plot) begin
          if (in_range) begin
            addr_d = plot_addr;
            data_d = |in_color;
            wren_d = 1'b1;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      StFill: begin
        if (addr_q == FillLast) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          wren_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= 1'b0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign ram_address = addr_q;
  assign ram_data    = data_q;
  assign ram_wren    = wren_q;
  assign busy        = busy_q;
  assign fill_done   = done_q;
  assign drop_count  = drop_q;

endmodule
